// File: rtl/popcount_display_if.sv
// Request/result bundle for popcount_display: the sampled data word plus the start, busy, done,
// count and seven-segment result lines.
interface popcount_display_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 2
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    iDATA;
    logic                iSTART;
    logic                oBUSY;
    logic                oDONE;
    logic [CW-1:0]       oCOUNT;
    logic [8*DIGITS-1:0] oSEG;

    modport master (
        output iDATA, iSTART,
        input  oBUSY, oDONE, oCOUNT, oSEG
    );

    modport slave (
        input  iDATA, iSTART,
        output oBUSY, oDONE, oCOUNT, oSEG
    );
endinterface

// File: rtl/popcount_display.sv
// Serial ones-counter with shift-add-3 BCD conversion driving active-low seven-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module popcount_display #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 2
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    popcount_display_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 8 * DIGITS;

    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(CW - 1);
    localparam logic [7:0]    SEG_DASH   = 8'hBF;
    localparam logic [7:0]    SEG_BLANK  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_CONVERT,
        S_DONE
    } state_t;

    function automatic logic [7:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Display pattern for a count of zero, used as the reset value of the segment register.
    function automatic logic [SW-1:0] seg_zero();
        logic [SW-1:0] v;
`ifdef LEADING_ZERO_BLANK_EN
        v = '1;
`else
        v = {DIGITS{8'hC0}};
`endif
        v[7:0] = 8'hC0;
        return v;
    endfunction

    localparam logic [SW-1:0] SEG_RESET = seg_zero();

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_acc;
    logic [CW-1:0]    r_bin;
    logic [CW-1:0]    r_step;
    logic [BW-1:0]    r_bcd;
    logic             r_ovf;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_seg;
    logic             r_done;

    logic [CW-1:0]    w_acc_next;
    logic [BW-1:0]    w_bcd_adj;
    logic [SW-1:0]    w_seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic             w_lead;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.iSTART)            w_next = S_COUNT;
            S_COUNT:   if (r_step == LAST_BIT)    w_next = S_CONVERT;
            S_CONVERT: if (r_step == LAST_SHIFT)  w_next = S_DONE;
            S_DONE:                               w_next = S_IDLE;
            default:                              w_next = S_IDLE;
        endcase
    end

    assign w_acc_next = r_acc + CW'(r_shift[0]);

    // Add-3 correction on every digit of 5 or more before the next left shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_seg = '1;
`ifdef LEADING_ZERO_BLANK_EN
        w_lead = 1'b1;
`endif
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (r_ovf) begin
                w_seg[8*d +: 8] = SEG_DASH;
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (w_lead && (d != 0) && (r_bcd[4*d +: 4] == 4'd0)) begin
                    w_seg[8*d +: 8] = SEG_BLANK;
                end else begin
                    w_lead          = 1'b0;
                    w_seg[8*d +: 8] = seg7(r_bcd[4*d +: 4]);
                end
`else
                w_seg[8*d +: 8] = seg7(r_bcd[4*d +: 4]);
`endif
            end
        end
    end

    // A one falling off the top BCD digit means the count does not fit the display.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_bin   <= '0;
            r_step  <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_seg   <= SEG_RESET;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.iSTART) begin
                        r_shift <= bus.iDATA;
                        r_acc   <= '0;
                        r_step  <= '0;
                    end
                end
                S_COUNT: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift >> 1;
                    if (r_step == LAST_BIT) begin
                        r_step <= '0;
                        r_bin  <= w_acc_next;
                        r_bcd  <= '0;
                        r_ovf  <= 1'b0;
                    end else begin
                        r_step <= r_step + CW'(1);
                    end
                end
                S_CONVERT: begin
                    r_bcd  <= {w_bcd_adj[BW-2:0], r_bin[CW-1]};
                    r_ovf  <= r_ovf | w_bcd_adj[BW-1];
                    r_bin  <= r_bin << 1;
                    r_step <= r_step + CW'(1);
                end
                S_DONE: begin
                    r_count <= r_acc;
                    r_seg   <= w_seg;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oBUSY  = (r_state != S_IDLE);
    assign bus.oDONE  = r_done;
    assign bus.oCOUNT = r_count;
    assign bus.oSEG   = r_seg;
endmodule

// File: tb/tb_popcount_display.sv
// Scoreboard bench for popcount_display: a 10-bit/2-digit instance and a 12-bit/1-digit instance.
module tb_popcount_display;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    typedef struct {
        string       name;
        logic [15:0] count;
        logic [15:0] seg;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    popcount_display_if #(.WIDTH(10), .DIGITS(2)) bus_a ();
    popcount_display_if #(.WIDTH(12), .DIGITS(1)) bus_b ();

    popcount_display #(.WIDTH(10), .DIGITS(2)) dut_a (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus_a.slave)
    );

    popcount_display #(.WIDTH(12), .DIGITS(1)) dut_b (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_a.oDONE) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", bus_a.oDONE, 1'b0);
            end else begin
                e = q_a.pop_front();
                check({e.name, "_count"},   bus_a.oCOUNT, e.count);
                check({e.name, "_seg"},     bus_a.oSEG,   e.seg);
                check({e.name, "_latency"}, cyc,          e.at);
                check({e.name, "_idle"},    bus_a.oBUSY,  1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_b.oDONE) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_done", bus_b.oDONE, 1'b0);
            end else begin
                e = q_b.pop_front();
                check({e.name, "_count"},   bus_b.oCOUNT, e.count);
                check({e.name, "_seg"},     bus_b.oSEG,   e.seg);
                check({e.name, "_latency"}, cyc,          e.at);
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while (bus_a.oBUSY && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus_a.oBUSY) check("a_idle_timeout", bus_a.oBUSY, 1'b0);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        @(negedge clk);
        while (bus_b.oBUSY && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus_b.oBUSY) check("b_idle_timeout", bus_b.oBUSY, 1'b0);
    endtask

    // Accepting edge is the next posedge; oDONE is seen W+CW+1 edges later at a negedge.
    task automatic start_a(input logic [9:0] d, input logic [15:0] c, input logic [15:0] s,
                           input string n);
        wait_idle_a();
        bus_a.iDATA  = d;
        bus_a.iSTART = 1'b1;
        q_a.push_back('{n, c, s, cyc + 16});
        @(negedge clk);
        bus_a.iSTART = 1'b0;
    endtask

    task automatic start_b(input logic [11:0] d, input logic [15:0] c, input logic [15:0] s,
                           input string n);
        wait_idle_b();
        bus_b.iDATA  = d;
        bus_b.iSTART = 1'b1;
        q_b.push_back('{n, c, s, cyc + 18});
        @(negedge clk);
        bus_b.iSTART = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", q_a.size() + q_b.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.iDATA  = '0;
        bus_a.iSTART = 1'b0;
        bus_b.iDATA  = '0;
        bus_b.iSTART = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_a_busy",  bus_a.oBUSY,  1'b0);
        check("rst_a_done",  bus_a.oDONE,  1'b0);
        check("rst_a_count", bus_a.oCOUNT, 0);
        check("rst_a_seg",   bus_a.oSEG,   {Z, 8'hC0});
        check("rst_b_seg",   bus_b.oSEG,   8'hC0);
        rst_n = 1'b1;

        // Directed vectors, counts and segment patterns worked out by hand.
        start_a(10'h3FF, 10, 16'hF9C0,      "a_all_ones");
        start_a(10'h007, 3,  {Z, 8'hB0},    "a_three");
        start_a(10'h000, 0,  {Z, 8'hC0},    "a_zero");
        start_a(10'h2AA, 5,  {Z, 8'h92},    "a_alt");
        start_a(10'h1F3, 7,  {Z, 8'hF8},    "a_seven");
        start_a(10'h3FE, 9,  {Z, 8'h90},    "a_nine");
        start_b(12'h3FF, 10, 16'h00BF,      "b_ten_dash");
        start_b(12'h000, 0,  16'h00C0,      "b_zero");
        start_b(12'hFFF, 12, 16'h00BF,      "b_all_ones_dash");
        start_b(12'h009, 2,  16'h00A4,      "b_two");
        start_b(12'h1FF, 9,  16'h0090,      "b_nine");
        drain();

        // A second request during a conversion and a data change after acceptance are ignored.
        start_a(10'h3FF, 10, 16'hF9C0, "a_ignore");
        repeat (4) @(negedge clk);
        bus_a.iDATA  = 10'h000;
        bus_a.iSTART = 1'b1;
        check("a_busy_mid", bus_a.oBUSY, 1'b1);
        @(negedge clk);
        bus_a.iSTART = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // iSTART held high restarts on the first IDLE edge: period WIDTH+CW+2.
        wait_idle_a();
        bus_a.iDATA  = 10'h3FF;
        bus_a.iSTART = 1'b1;
        q_a.push_back('{"a_b2b_first",  10, 16'hF9C0,   cyc + 16});
        q_a.push_back('{"a_b2b_second", 3,  {Z, 8'hB0}, cyc + 32});
        repeat (16) @(negedge clk);
        bus_a.iDATA = 10'h007;
        @(negedge clk);
        bus_a.iSTART = 1'b0;
        check("a_busy_b2b", bus_a.oBUSY, 1'b1);
        drain();

        // Reset in the middle of a conversion abandons it at once.
        wait_idle_a();
        bus_a.iDATA  = 10'h3FF;
        bus_a.iSTART = 1'b1;
        @(negedge clk);
        bus_a.iSTART = 1'b0;
        repeat (7) @(negedge clk);
        check("a_busy_before_reset", bus_a.oBUSY, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_busy",  bus_a.oBUSY,  1'b0);
        check("mid_rst_a_done",  bus_a.oDONE,  1'b0);
        check("mid_rst_a_count", bus_a.oCOUNT, 0);
        check("mid_rst_a_seg",   bus_a.oSEG,   {Z, 8'hC0});
        check("mid_rst_b_count", bus_b.oCOUNT, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("a_quiet_after_reset", bus_a.oBUSY, 1'b0);
        start_a(10'h007, 3, {Z, 8'hB0}, "a_after_reset");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/popcount_display.md
POPCOUNT_DISPLAY -- requirements
Module: popcount_display

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of input bits counted (2..64).
REQ-002 SHALL have parameter DIGITS, default 2, number of decimal seven-segment digits driven (1..6).
REQ-003 SHALL have port iCLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iDATA  input  WIDTH  word whose set bits are counted.
REQ-006 SHALL have port iSTART  input  1  request; samples iDATA when idle.
REQ-007 SHALL have port oBUSY  output  1  high while a conversion is in progress.
REQ-008 SHALL have port oDONE  output  1  one-cycle pulse when a result is published.
REQ-009 SHALL have port oCOUNT  output  CW  last published ones count, CW = clog2(WIDTH+1).
REQ-010 SHALL have port oSEG  output  8*DIGITS  active-low segments; byte k = digit k (k=0 units), bit7 = dp.

Function
REQ-011 SHALL implement FSM states IDLE, COUNT, CONVERT, DONE; reset state IDLE.
REQ-012 IDLE: iSTART=1 at an edge SHALL latch iDATA into a shift register, clear the accumulator and go to COUNT.
REQ-013 COUNT: SHALL examine one bit per cycle (LSB first), add it to the CW-bit accumulator, and stay exactly WIDTH cycles before going to CONVERT.
REQ-014 CONVERT: SHALL perform shift-add-3 binary-to-BCD, one bit per cycle, exactly CW cycles, then go to DONE.
REQ-015 DONE: SHALL update oCOUNT and oSEG, assert oDONE for that one cycle, then return to IDLE.
REQ-016 oDONE SHALL be high exactly WIDTH+CW+1 edges after the edge that accepted iSTART.
REQ-017 oBUSY SHALL be high in COUNT, CONVERT and DONE, low in IDLE.
REQ-018 iSTART while oBUSY=1 SHALL be ignored (no queuing); iDATA changes after acceptance SHALL not affect the result.
REQ-019 iSTART held high SHALL start a new conversion on the first IDLE edge after DONE (back-to-back period WIDTH+CW+2).
REQ-020 oCOUNT and oSEG SHALL hold their previous values until DONE; they never show intermediate values.
REQ-021 Digit encoding (dp off, bit7=1): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 hex.
REQ-022 If the count exceeds 10^DIGITS-1, all digits SHALL show dash (BF hex); oCOUNT still holds the true count.
REQ-023 Count 0 SHALL display digit 0 as C0; count = WIDTH (all ones) SHALL be exact, no wrap of the accumulator.

Reset
REQ-024 iRST_N low SHALL immediately force IDLE, oBUSY=0, oDONE=0, oCOUNT=0, all internal registers 0.
REQ-025 Under reset oSEG SHALL show the value 0 per REQ-021 and REQ-026 (digit 0 = C0).
REQ-026 Reset asserted mid-conversion SHALL abandon it; no oDONE pulse follows release; first iSTART after release behaves per REQ-012.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: leading zero digits above the most significant non-zero digit SHALL display FF (blank); digit 0 never blanked.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: all DIGITS digits SHALL display their BCD value, leading zeros as C0.
REQ-029 The macro SHALL not alter timing, oCOUNT, oDONE or dash overflow behaviour.

Verification
REQ-030 WIDTH=10, DIGITS=2, iDATA=3FF, iSTART pulse -> oDONE 15 edges later, oCOUNT=10, oSEG={F9,C0}.
REQ-031 WIDTH=10, DIGITS=2, iDATA=007 -> oCOUNT=3; with LEADING_ZERO_BLANK_EN oSEG={FF,B0}, without {C0,B0}.
REQ-032 WIDTH=12, DIGITS=1, iDATA=3FF -> oCOUNT=10, oSEG=BF (dash); iDATA=000 -> oCOUNT=0, oSEG=C0.
REQ-033 Start with iDATA=3FF, second iSTART with 000 at cycle 5 -> ignored; result 10; iSTART held high -> next oDONE 16 cycles after the first.
REQ-034 iRST_N low at cycle 8 of a conversion -> oBUSY=0, oCOUNT=0, oSEG digit 0=C0 at once; no oDONE until a new iSTART.
